csi_packet_decoder: RTL

Single-lane MIPI CSI-2 packet decoder for the camera receive path. It consumes the HS byte stream recovered by the D-PHY receiver, one packet per HS burst, and parses packet headers. It checks header ECC and payload CRC, and unpacks RAW10 long packets into 10-bit pixels with frame and line valid. It is the receive-side counterpart of the pix2byte/csi_tx transmit chain used in top-level simulation.

---
 rtl/csi_packet_decoder.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/csi_packet_decoder.sv
// ---------------------------------------------------------------------------
// csi_packet_decoder
// Single-lane MIPI CSI-2 receive-side packet decoder. Parses the 4-byte packet
// header of every HS burst, checks its ECC, tracks Frame Start / Frame End,
// unpacks RAW10 long packets into 10-bit pixels and checks the payload CRC.
//
// Ports
//   clk           byte clock (only clock)
//   reset         synchronous, active-high reset
//   byte_data_en  high for the whole HS burst, one byte per cycle
//   byte_data     packet byte
//   frame_valid   high between an accepted Frame Start and Frame End
//   line_valid    high from the first pixel of a RAW10 line to one cycle
//                 after its last pixel
//   pixel_en      qualifies pixel_data
//   pixel_data    unpacked 10-bit pixel (holds when pixel_en is low)
//   frame_number  WC of the last accepted Frame Start
//   ecc_error     one-cycle pulse: header ECC mismatch
//   crc_error     one-cycle pulse: payload CRC mismatch
//   trunc_error   one-cycle pulse: burst ended inside header/payload/CRC
// ---------------------------------------------------------------------------
module csi_packet_decoder #(
    parameter logic [1:0] VC       = 2'd0,
    parameter logic [5:0] DT_RAW10 = 6'h2B
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_data_en,
    input  logic [7:0]  byte_data,
    output logic        frame_valid,
    output logic        line_valid,
    output logic        pixel_en,
    output logic [9:0]  pixel_data,
    output logic [15:0] frame_number,
    output logic        ecc_error,
    output logic        crc_error,
    output logic        trunc_error
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CRC     = 3'd3,
        ST_SKIP    = 3'd4
    } state_e;

    // 6-bit header Hamming code; bit k is the parity of the header bits in mask k.
    function automatic logic [5:0] hdr_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return p;
    endfunction

    // Reflected CRC-16 (0x8408) advanced by one byte.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [7:0]  di_q, di_d;
    logic [15:0] wc_q, wc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  crc_lo_q, crc_lo_d;
    logic        crc_byte_q, crc_byte_d;
    logic [2:0]  grp_idx_q, grp_idx_d;
    logic [31:0] grp_q, grp_d;
    logic [29:0] hold_q, hold_d;
    logic [1:0]  hold_cnt_q, hold_cnt_d;
    logic        frame_valid_q, frame_valid_d;
    logic        line_valid_q, line_valid_d;
    logic        pixel_en_q, pixel_en_d;
    logic [9:0]  pixel_data_q, pixel_data_d;
    logic [15:0] frame_number_q, frame_number_d;
    logic        ecc_error_q, ecc_error_d;
    logic        crc_error_q, crc_error_d;
    logic        trunc_error_q, trunc_error_d;

    logic        ecc_ok_s;
    logic        grp_load_s;

    // The current byte is the ECC byte when this is evaluated in HDR with hdr_cnt_q == 2.
    assign ecc_ok_s   = (byte_data == {2'b00, hdr_ecc({wc_q, di_q})});
    // The fifth byte of a group (B4) completes four pixels.
    assign grp_load_s = (state_q == ST_PAYLOAD) && byte_data_en && (grp_idx_q == 3'd4);

    // Packet FSM: header parse, payload count, CRC compare, frame tracking.
    always_comb begin
        state_d        = state_q;
        hdr_cnt_d      = hdr_cnt_q;
        di_d           = di_q;
        wc_d           = wc_q;
        cnt_d          = cnt_q;
        crc_d          = crc_q;
        crc_lo_d       = crc_lo_q;
        crc_byte_d     = crc_byte_q;
        grp_idx_d      = grp_idx_q;
        grp_d          = grp_q;
        frame_valid_d  = frame_valid_q;
        frame_number_d = frame_number_q;
        ecc_error_d    = 1'b0;
        crc_error_d    = 1'b0;
        trunc_error_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (byte_data_en) begin
                    di_d      = byte_data;
                    hdr_cnt_d = 2'd0;
                    state_d   = ST_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (!byte_data_en) begin
                    trunc_error_d = 1'b1;
                    state_d       = ST_IDLE;
                end else if (hdr_cnt_q == 2'd0) begin
                    wc_d[7:0] = byte_data;
                    hdr_cnt_d = 2'd1;
                end else if (hdr_cnt_q == 2'd1) begin
                    wc_d[15:8] = byte_data;
                    hdr_cnt_d  = 2'd2;
                end else begin
                    state_d = ST_SKIP;
                    if (!ecc_ok_s) begin
                        ecc_error_d = 1'b1;
                    end else if (di_q[7:6] != VC) begin
                        state_d = ST_SKIP;
                    end else if (di_q[5:0] == 6'h00) begin
                        frame_valid_d  = 1'b1;
                        frame_number_d = wc_q;
                    end else if (di_q[5:0] == 6'h01) begin
                        frame_valid_d = 1'b0;
                    end else if (di_q[5:0] == DT_RAW10) begin
                        crc_d      = 16'hFFFF;
                        cnt_d      = wc_q;
                        grp_idx_d  = 3'd0;
                        crc_byte_d = 1'b0;
                        state_d    = (wc_q == 16'd0) ? ST_CRC : ST_PAYLOAD;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!byte_data_en) begin
                    trunc_error_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    crc_d = crc16_byte(crc_q, byte_data);
                    cnt_d = cnt_q - 16'd1;
                    if (grp_idx_q == 3'd4) begin
                        grp_idx_d = 3'd0;
                    end else begin
                        grp_d[{grp_idx_q[1:0], 3'b000} +: 8] = byte_data;
                        grp_idx_d = grp_idx_q + 3'd1;
                    end
                    if (cnt_q == 16'd1) begin
                        crc_byte_d = 1'b0;
                        state_d    = ST_CRC;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_CRC: begin
                if (!byte_data_en) begin
                    trunc_error_d = 1'b1;
                    state_d       = ST_IDLE;
                end else if (!crc_byte_q) begin
                    crc_lo_d   = byte_data;
                    crc_byte_d = 1'b1;
                end else begin
                    crc_error_d = ({byte_data, crc_lo_q} != crc_q);
                    state_d     = ST_SKIP;
                end
            end
            ST_SKIP: begin
                if (!byte_data_en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SKIP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pixel pipe: pixel 0 leaves directly on B4, pixels 1..3 drain from the holding register.
    always_comb begin
        pixel_en_d   = 1'b0;
        pixel_data_d = pixel_data_q;
        hold_d       = hold_q;
        hold_cnt_d   = hold_cnt_q;
        if (grp_load_s) begin
            pixel_en_d   = 1'b1;
            pixel_data_d = {grp_q[7:0], byte_data[1:0]};
            hold_d       = {grp_q[31:24], byte_data[7:6],
                            grp_q[23:16], byte_data[5:4],
                            grp_q[15:8],  byte_data[3:2]};
            hold_cnt_d   = 2'd3;
        end else if (hold_cnt_q != 2'd0) begin
            pixel_en_d   = 1'b1;
            pixel_data_d = hold_q[9:0];
            hold_d       = {10'd0, hold_q[29:10]};
            hold_cnt_d   = hold_cnt_q - 2'd1;
        end else begin
            pixel_en_d = 1'b0;
        end
        // Pixels of a line arrive as 4-on/1-off; covering the cycle after each
        // pixel bridges the gap and leaves line_valid high 5 cycles per group.
        line_valid_d = pixel_en_d | pixel_en_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            hdr_cnt_q      <= 2'd0;
            di_q           <= 8'd0;
            wc_q           <= 16'd0;
            cnt_q          <= 16'd0;
            crc_q          <= 16'hFFFF;
            crc_lo_q       <= 8'd0;
            crc_byte_q     <= 1'b0;
            grp_idx_q      <= 3'd0;
            grp_q          <= 32'd0;
            hold_q         <= 30'd0;
            hold_cnt_q     <= 2'd0;
            frame_valid_q  <= 1'b0;
            line_valid_q   <= 1'b0;
            pixel_en_q     <= 1'b0;
            pixel_data_q   <= 10'd0;
            frame_number_q <= 16'd0;
            ecc_error_q    <= 1'b0;
            crc_error_q    <= 1'b0;
            trunc_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            hdr_cnt_q      <= hdr_cnt_d;
            di_q           <= di_d;
            wc_q           <= wc_d;
            cnt_q          <= cnt_d;
            crc_q          <= crc_d;
            crc_lo_q       <= crc_lo_d;
            crc_byte_q     <= crc_byte_d;
            grp_idx_q      <= grp_idx_d;
            grp_q          <= grp_d;
            hold_q         <= hold_d;
            hold_cnt_q     <= hold_cnt_d;
            frame_valid_q  <= frame_valid_d;
            line_valid_q   <= line_valid_d;
            pixel_en_q     <= pixel_en_d;
            pixel_data_q   <= pixel_data_d;
            frame_number_q <= frame_number_d;
            ecc_error_q    <= ecc_error_d;
            crc_error_q    <= crc_error_d;
            trunc_error_q  <= trunc_error_d;
        end
    end

    assign frame_valid  = frame_valid_q;
    assign line_valid   = line_valid_q;
    assign pixel_en     = pixel_en_q;
    assign pixel_data   = pixel_data_q;
    assign frame_number = frame_number_q;
    assign ecc_error    = ecc_error_q;
    assign crc_error    = crc_error_q;
    assign trunc_error  = trunc_error_q;

endmodule
